// File: rtl/mdu_seq.sv
// ============================================================================
// Module   : mdu_seq
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  op_l;
    logic [31:0] a_l;
    logic [31:0] b_l;
    logic [31:0] mag;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;

    logic        is_signed;
    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mult_sum;
    logic [32:0] div_top;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_signed = ~op_l[0];
    assign is_div    = op_l[1];
    assign mag_a     = (is_signed && a_l[31]) ? (32'd0 - a_l) : a_l;
    assign mag_b     = (is_signed && b_l[31]) ? (32'd0 - b_l) : b_l;

    // acc holds {partial product, multiplier} or {remainder, quotient}
    assign mult_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag : 32'd0)};
    assign div_top   = acc[63:31];
    assign div_ge    = (div_top >= {1'b0, mag});
    assign div_rem   = div_top[31:0] - mag;

    assign prod_fix  = neg_q ? (64'd0 - acc) : acc;
    assign quo_fix   = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix   = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_l  <= 2'd0;
            a_l   <= 32'd0;
            b_l   <= 32'd0;
            mag   <= 32'd0;
            acc   <= 64'd0;
            cnt   <= 5'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is still high during the done cycle, so writes wait
                    if (!busy && we_hi) hi <= wdata;
                    if (!busy && we_lo) lo <= wdata;
                    if (start && !cancel) begin
                        op_l  <= op;
                        a_l   <= a;
                        b_l   <= b;
                        state <= S_PREP;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        mag   <= is_div ? mag_b : mag_a;
                        acc   <= {32'd0, (is_div ? mag_a : mag_b)};
                        cnt   <= 5'd0;
                        neg_q <= is_signed & (a_l[31] ^ b_l[31]);
                        neg_r <= is_signed & is_div & a_l[31];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div)
                            acc <= div_ge ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
                        else
                            acc <= {mult_sum, acc[31:1]};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (cancel) begin
                        busy <= 1'b0;
                    end else begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
